// File: rtl/classify_queue.sv
// classify_queue: buffered opcode classifier between fetch and decode.
// Each instruction is classified (R / I / J / illegal) as it is enqueued, and
// the class flags are stored alongside the instruction and its PC in a
// DEPTH-entry FIFO. The head entry is presented to decode. Flush discards
// everything that is queued.
// Optional build macro CLASSIFY_BYPASS_EN: when the queue is empty, an offered
// instruction is presented to decode in the same cycle, and it is never written
// if decode takes it immediately.
module classify_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_instr,
  input  logic [PC_WIDTH-1:0]        in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_is_r,
  output logic                       out_is_i,
  output logic                       out_is_j,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]   pc;
    logic                  is_r;
    logic                  is_i;
    logic                  is_j;
    logic                  illegal;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_ent;
  entry_t          out_ent;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   cnt;
  logic            empty, push, pop, wr_en, show_in;

  assign count    = cnt;
  assign empty    = (cnt == '0);
  // Ready depends only on occupancy, so a full queue refuses input even when
  // decode pops in the same cycle.
  assign in_ready = (cnt < CW'(DEPTH));
  assign push     = in_valid & in_ready;
  // Pops only ever come out of storage; a bypassed word is not a pop.
  assign pop      = ~empty & out_ready;

`ifdef CLASSIFY_BYPASS_EN
  logic bypass;
  assign bypass  = empty & in_valid;
  assign show_in = bypass & ~flush;
  assign wr_en   = push & ~flush & ~(bypass & out_ready);
`else
  assign show_in = 1'b0;
  assign wr_en   = push & ~flush;
`endif

  // Live classification of the offered word by its opcode field
  always_comb begin
    in_ent       = '0;
    in_ent.instr = in_instr;
    in_ent.pc    = in_pc;
    unique case (in_instr[31:26])
      6'h00:                      in_ent.is_r    = 1'b1;
      6'h09, 6'h0D, 6'h0F, 6'h23,
      6'h2B, 6'h28, 6'h01, 6'h04,
      6'h05:                      in_ent.is_i    = 1'b1;
      6'h02, 6'h03:               in_ent.is_j    = 1'b1;
      default:                    in_ent.illegal = 1'b1;
    endcase
  end

  // Head selection: stored head, bypassed live word, or all-zero when empty
  always_comb begin
    out_ent = '0;
    if (!empty)       out_ent = mem[rd_ptr];
    else if (show_in) out_ent = in_ent;
  end

  assign out_valid   = ~empty | show_in;
  assign out_instr   = out_ent.instr;
  assign out_pc      = out_ent.pc;
  assign out_is_r    = out_ent.is_r;
  assign out_is_i    = out_ent.is_i;
  assign out_is_j    = out_ent.is_j;
  assign out_illegal = out_ent.illegal;

  // Entry storage; contents need no reset because occupancy gates the outputs
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_ent;
  end

  // Pointers and occupancy; flush has priority over push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_classify_queue.sv
// Bench for classify_queue: a queue-based reference model checked every
// negative edge, plus directed steps with literal expectations.
module tb_classify_queue;
  localparam int DEPTH = 4;
`ifdef CLASSIFY_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic        in_ready, out_valid, out_is_r, out_is_i, out_is_j, out_illegal;
  logic [31:0] out_instr, out_pc;
  logic [2:0]  count;

  classify_queue #(.DATA_WIDTH(32), .PC_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_is_r(out_is_r), .out_is_i(out_is_i),
    .out_is_j(out_is_j), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t q[$];

  // Class from the opcode lists: {illegal, j, i, r}
  function automatic logic [3:0] cls_of(logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (op == 6'h00) return 4'b0001;
    if (op inside {6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h28, 6'h01, 6'h04, 6'h05}) return 4'b0010;
    if (op inside {6'h02, 6'h03}) return 4'b0100;
    return 4'b1000;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] dut_flags();
    return {out_illegal, out_is_j, out_is_i, out_is_r};
  endfunction

  // Reference model update
  always @(posedge clk or posedge rst) begin
    if (rst) q.delete();
    else if (flush) q.delete();
    else begin
      automatic bit do_push = in_valid && (q.size() < DEPTH);
      automatic bit do_pop  = (q.size() > 0) && out_ready;
      automatic bit consume = BYP && (q.size() == 0) && in_valid && out_ready;
      automatic ent_t e;
      e.instr = in_instr;
      e.pc    = in_pc;
      if (do_pop) void'(q.pop_front());
      if (do_push && !consume) q.push_back(e);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic        ev;
    logic [31:0] ei, ep;
    logic [3:0]  ec;
    ev = 0; ei = 0; ep = 0; ec = 0;
    if (q.size() > 0) begin
      ev = 1; ei = q[0].instr; ep = q[0].pc; ec = cls_of(ei);
    end else if (BYP && in_valid && !flush && !rst) begin
      ev = 1; ei = in_instr; ep = in_pc; ec = cls_of(in_instr);
    end
    chk("m_out_valid", out_valid, ev);
    chk("m_in_ready", in_ready, (q.size() < DEPTH));
    chk("m_count", count, q.size());
    chk("m_out_instr", out_instr, ei);
    chk("m_out_pc", out_pc, ep);
    chk("m_flags", dut_flags(), ec);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  logic [31:0] words [4] = '{32'h0000_000C, 32'h0C10_0000, 32'hFC00_0000, 32'h3C01_1001};
  logic [5:0]  pool [12] = '{6'h00, 6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B,
                             6'h28, 6'h01, 6'h04, 6'h05, 6'h02, 6'h03};

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    settle();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_count", count, 0);
    chk("reset_flags", dut_flags(), 0);

    // ADDIU, one-cycle latency
    in_valid = 1; in_instr = 32'h2408_0005; in_pc = 32'h0040_0000; out_ready = 0;
    tick();
    in_valid = 0;
    settle();
    chk("addiu_valid", out_valid, 1);
    chk("addiu_is_i", dut_flags(), 4'b0010);
    chk("addiu_pc", out_pc, 32'h0040_0000);
    chk("addiu_count", count, 1);
    out_ready = 1; tick(); out_ready = 0;

    // Fill with four words of distinct classes
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_instr = words[k]; in_pc = 32'h1000 + 32'(4 * k);
      tick();
    end
    in_valid = 0;
    settle();
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("head_r", dut_flags(), 4'b0001);
    chk("head_r_instr", out_instr, 32'h0000_000C);

    // Full with push offered and pop: offered word refused
    in_valid = 1; in_instr = 32'hDEAD_BEEF; out_ready = 1;
    tick();
    in_valid = 0; out_ready = 0;
    settle();
    chk("fullpop_count", count, 3);
    chk("head_j", dut_flags(), 4'b0100);
    chk("head_j_instr", out_instr, 32'h0C10_0000);
    out_ready = 1; tick(); out_ready = 0; settle();
    chk("head_ill", dut_flags(), 4'b1000);
    out_ready = 1; tick(); out_ready = 0; settle();
    chk("head_lui", dut_flags(), 4'b0010);
    chk("head_lui_instr", out_instr, 32'h3C01_1001);

    // Two more, then continuous push+pop across pointer wrap
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_instr = 32'h2400_0000 + 32'(k); in_pc = 32'h2000 + 32'(4 * k);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      in_valid = 1; out_ready = 1; in_instr = $urandom(); in_pc = 32'h3000 + 32'(4 * k);
      tick();
    end
    in_valid = 0; out_ready = 0;
    settle();
    chk("stream_count", count, 3);

    // Flush with simultaneous push
    flush = 1; in_valid = 1; in_instr = 32'h0800_BEEF; in_pc = 32'h5555;
    tick();
    flush = 0; in_valid = 0;
    settle();
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_flags", dut_flags(), 0);

    // Async reset mid-stream
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_instr = 32'h0000_0020 + 32'(k); in_pc = 32'h6000 + 32'(4 * k);
      tick();
    end
    in_valid = 0;
    settle();
    chk("prerst_count", count, 2);
    @(posedge clk); #3 rst = 1; #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_count", count, 0);
    chk("rst_flags", dut_flags(), 0);
    @(negedge clk); rst = 0; #1;
    chk("rstrel_in_ready", in_ready, 1);
    chk("rstrel_count", count, 0);

`ifdef CLASSIFY_BYPASS_EN
    tick();
    in_valid = 1; in_instr = 32'h0800_0010; in_pc = 32'h7000; out_ready = 1;
    #1;
    chk("byp_valid", out_valid, 1);
    chk("byp_is_j", dut_flags(), 4'b0100);
    chk("byp_instr", out_instr, 32'h0800_0010);
    tick();
    in_valid = 0; out_ready = 0;
    settle();
    chk("byp_count", count, 0);
`endif

    // Randomized traffic, with a slow-consumer phase to reach full often
    for (int n = 0; n < 800; n++) begin
      logic [31:0] r;
      logic [5:0]  op;
      r  = $urandom();
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : pool[$urandom_range(0, 11)];
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ((n % 200) < 60) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_instr  = {op, r[25:0]};
      in_pc     = $urandom();
      tick();
    end
    in_valid = 0; out_ready = 0; flush = 0;
    settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
